// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Start/busy/done handshake; a zero divisor completes without entering RUN and raises dbz.
module seq_divider #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             dbz
);

    localparam int CW = $clog2(2 * N);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [2*N-1:0]   dvd_q, dvd_d;
    logic [N-1:0]     dvs_q, dvs_d;
    logic [N:0]       rem_q, rem_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             zpend_q, zpend_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2*N-1:0]   quotient_q, quotient_d;
    logic [N-1:0]     remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [N:0]       r_shift;
    logic [N:0]       r_sub;
    logic             q_bit;
    logic [N:0]       r_next;
    logic [2*N-1:0]   acc_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        r_shift  = {rem_q[N-1:0], dvd_q[2*N-1]};
        r_sub    = r_shift - {1'b0, dvs_q};
        q_bit    = (r_shift >= {1'b0, dvs_q});
        r_next   = q_bit ? r_sub : r_shift;
        acc_next = {acc_q[2*N-2:0], q_bit};
    end

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        zpend_d     = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (zpend_q) begin
                    // Zero divisor seen last edge: report a saturated result now.
                    done_d      = 1'b1;
                    dbz_d       = 1'b1;
                    quotient_d  = '1;
                    remainder_d = '0;
                end else if (start) begin
                    if (divisor != '0) begin
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        rem_d   = '0;
                        acc_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        zpend_d = 1'b1;
                    end
                end
            end
            RUN: begin
                rem_d = r_next;
                dvd_d = {dvd_q[2*N-2:0], 1'b0};
                acc_d = acc_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(2 * N - 1)) begin
                    quotient_d  = acc_next;
                    remainder_d = r_next[N-1:0];
                    done_d      = 1'b1;
                    dbz_d       = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            zpend_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            zpend_q     <= zpend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=4): directed cases plus random operands
// compared against plain integer division.
module tb_seq_divider;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [2*N-1:0] dividend = '0;
    logic [N-1:0]   divisor = '0;
    logic           busy;
    logic           done;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           dbz;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance until done is seen; counts cycles after the start edge and cycles with busy high.
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            if (busy === 1'b1) busy_cycles++;
            tick();
            cycles++;
        end
    endtask

    // Reference model: plain arithmetic, saturated result for a zero divisor.
    task automatic model(input int a, input int b, output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << (2 * N)) - 1;
            r = 0;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endtask

    task automatic run_div(input int a, input int b, input string tag);
        int q, r, z, cyc, bcyc;
        model(a, b, q, r, z);
        dividend = (2*N)'(a);
        divisor  = N'(b);
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc, bcyc);
        check({tag, ".latency"}, cyc, (b == 0) ? 1 : 2 * N);
        check({tag, ".busy_cycles"}, bcyc, (b == 0) ? 0 : 2 * N);
        check({tag, ".quotient"}, quotient, q);
        check({tag, ".remainder"}, remainder, r);
        check({tag, ".dbz"}, dbz, z);
        $display("txn %s: %0d / %0d -> q=%0d r=%0d dbz=%0b after %0d cycles",
                 tag, a, b, quotient, remainder, dbz, cyc);
        tick();
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".held_q"}, quotient, q);
        check({tag, ".held_dbz"}, dbz, z);
    endtask

    initial begin
        int cyc, bcyc, ndone;

        tick();
        tick();
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.dbz", dbz, 0);
        check("reset.quotient", quotient, 0);
        check("reset.remainder", remainder, 0);
        rst = 1'b0;
        tick();

        run_div(200, 7, "d200_7");
        run_div(255, 1, "d255_1");
        run_div(225, 15, "d225_15");
        run_div(0, 3, "d0_3");
        run_div(14, 15, "d14_15");
        run_div(100, 0, "d100_0");
        run_div(100, 10, "d100_10");

        // start pulsed mid-run with new operands must be ignored
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        dividend = 8'd50;
        divisor  = 4'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc, bcyc);
        check("ignore.quotient", quotient, 28);
        check("ignore.remainder", remainder, 4);
        ndone = 1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        check("ignore.done_count", ndone, 1);
        $display("txn ignore-start: q=%0d r=%0d dones=%0d", quotient, remainder, ndone);

        // reset mid-run discards the division
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst.busy", busy, 0);
        check("midrst.done", done, 0);
        check("midrst.quotient", quotient, 0);
        check("midrst.remainder", remainder, 0);
        check("midrst.dbz", dbz, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        check("midrst.no_done", ndone, 0);
        $display("txn mid-run reset: dones after reset=%0d", ndone);
        run_div(9, 2, "d9_2");

        // back-to-back: start held in the done cycle
        dividend = 8'd60;
        divisor  = 4'd4;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc, bcyc);
        check("b2b.first_q", quotient, 15);
        check("b2b.first_r", remainder, 0);
        $display("txn b2b first: q=%0d r=%0d", quotient, remainder);
        dividend = 8'd61;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc, bcyc);
        check("b2b.spacing", cyc + 1, 2 * N + 1);
        check("b2b.second_q", quotient, 15);
        check("b2b.second_r", remainder, 1);
        $display("txn b2b second: q=%0d r=%0d spacing=%0d", quotient, remainder, cyc + 1);
        tick();

        for (int i = 0; i < 30; i++) begin
            int a, b;
            a = int'($urandom_range(0, 255));
            b = (i % 10 == 9) ? 0 : int'($urandom_range(1, 15));
            run_div(a, b, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential restoring divider that inverts the team's combinational 4x4 array multiplier. It splits a 2N-bit dividend by an N-bit divisor into a 2N-bit quotient and an N-bit remainder, resolving one quotient bit per clock. It sits beside the multiplier in the arithmetic datapath and is driven through a start/busy/done handshake.

## Interface
- N, 4: divisor and remainder width. Dividend and quotient are 2N bits.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while idle.
- dividend  in  2N  numerator; captured on the accepted start edge.
- divisor  in  N  denominator; captured on the accepted start edge.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- quotient  out  2N  result; held until the next accepted start.
- remainder  out  N  result; held until the next accepted start.
- dbz  out  1  divide-by-zero flag; valid with done and held with the results.

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE & start & divisor!=0:
  - Latch the operands.
  - Clear the partial remainder (N+1 bits) and the bit counter.
  - Go to RUN.
- IDLE & start & divisor==0:
  - Stay in IDLE. Do not enter RUN.
  - Next edge: done<=1, dbz<=1, quotient<=all ones (2^(2N)-1), remainder<=0.
- RUN, one iteration per edge, MSB of dividend first:
  - R' = {R[N-1:0], next dividend bit}.
  - If R' >= {0,divisor}: R <= R' - divisor and q bit = 1.
  - Otherwise: R <= R' and q bit = 0.
- Quotient bits shift in from the LSB.
- The counter runs 0..2N-1. The iteration with counter = 2N-1:
  - writes quotient and remainder (R[N-1:0]);
  - sets done<=1, dbz<=0, busy<=0;
  - returns the FSM to IDLE.
- Compare and subtract use N+1 bits. R never exceeds 2·divisor−1, so no overflow is possible.
- start while busy: ignored, no queuing.
- Operand changes after the accepted start edge: no effect.
- done deasserts on the edge after it rises, unconditionally.
- Results and dbz hold until the next accepted start edge. On that edge quotient, remainder and dbz are not cleared; they are overwritten only at completion.

## Timing
- Reset: busy=0, done=0, dbz=0, quotient=0, remainder=0, state IDLE, counter=0.
- Latency, start sampled at edge E0, divisor nonzero:
  - busy is high from E0 through E2N.
  - done is high in the cycle after E2N: 2N cycles after the start edge, 8 for N=4.
- Latency, divide-by-zero: done high in the cycle after E1. busy never rises.
- Back-to-back: start may be asserted in the done cycle (state is IDLE) and is accepted. Throughput is one result per 2N+1 cycles (for N=4: start at E0, done high after E2N, next start at E2N+1).
- rst mid-RUN: the next edge forces all reset values. Any in-flight division is discarded and no done is produced.
- rst and start on the same edge: reset wins.

## Test plan
- Reset, then 200/7: done exactly 8 cycles after the start edge, quotient=28, remainder=4, dbz=0; busy high for exactly 8 cycles.
- 255/1 -> quotient=255, remainder=0. 225/15 (inverse of the largest 4x4 product) -> quotient=15, remainder=0. 0/3 -> 0,0. 14/15 -> 0,14.
- 100/0 -> done one cycle after start, dbz=1, quotient=255, remainder=0, busy never high. A following 100/10 -> dbz=0, quotient=10, remainder=0.
- Start 200/7; at cycle 3 pulse start with 50/5 and change the operand inputs -> result still 28 r 4; only one done.
- Start 200/7; assert rst at cycle 4 -> every output is 0 on the next edge and no done follows. Then 9/2 -> quotient=4, remainder=1.
- Back-to-back: 60/4 then 61/4, with start held high in the done cycle -> done pulses 9 cycles apart: 15 r 0, then 15 r 1.
